// File: rtl/mcse_lc_request_loader.sv
// Lifecycle request loader: gathers transition and authentication IDs from
// 32-bit host words, then presents them to the MCSE control unit as a
// one-cycle request pulse followed by a timed authentication window.
// Identifiers are exposed only while a request is in flight and are
// zeroized afterwards.
module mcse_lc_request_loader #(
   parameter int unsigned ID_WIDTH  = 256,
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned AUTH_HOLD = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   input  logic                wr_sel,
   input  logic [WORD_W-1:0]   wr_data,
   input  logic                go,
   input  logic                abort,
   input  logic                err_clr,
   output logic [ID_WIDTH-1:0] lc_transition_id,
   output logic                lc_transition_request,
   output logic [ID_WIDTH-1:0] lc_authentication_id,
   output logic                lc_authentication_valid,
   output logic                busy,
   output logic                trans_full,
   output logic                auth_full,
   output logic                err
);

   localparam int unsigned NumWords = ID_WIDTH / WORD_W;
   localparam int unsigned CntW     = $clog2(NumWords + 1);
   localparam logic [CntW-1:0] NumWordsC = CntW'(NumWords);
   localparam logic [7:0]      HoldLast  = 8'(AUTH_HOLD - 1);

   typedef enum logic [1:0] {StIdle, StReq, StAuth, StClear} state_e;

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] trans_buf_q, trans_buf_d;
   logic [ID_WIDTH-1:0] auth_buf_q, auth_buf_d;
   logic [CntW-1:0]     trans_cnt_q, trans_cnt_d;
   logic [CntW-1:0]     auth_cnt_q, auth_cnt_d;
   logic [7:0]          hold_cnt_q, hold_cnt_d;
   logic                err_q, err_d;
   logic                err_set;
   logic                both_full;
   logic                expose;

   assign trans_full = (trans_cnt_q == NumWordsC);
   assign auth_full  = (auth_cnt_q == NumWordsC);
   assign both_full  = trans_full && auth_full;

   // Outputs decode registered state only, so no input reaches an output combinationally.
   assign busy                    = (state_q != StIdle);
   assign lc_transition_request   = (state_q == StReq);
   assign lc_authentication_valid = (state_q == StAuth);
   assign expose                  = (state_q == StReq) || (state_q == StAuth);
   assign lc_transition_id        = expose ? trans_buf_q : '0;
   assign lc_authentication_id    = expose ? auth_buf_q : '0;
   assign err                     = err_q;

   // Next-state, buffer fill, hold timer and error detection.
   always_comb begin
      state_d     = state_q;
      trans_buf_d = trans_buf_q;
      auth_buf_d  = auth_buf_q;
      trans_cnt_d = trans_cnt_q;
      auth_cnt_d  = auth_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      err_set     = 1'b0;

      if (abort) begin
         // Cancel wins over everything; coincident writes/go are silently discarded.
         state_d     = StIdle;
         trans_buf_d = '0;
         auth_buf_d  = '0;
         trans_cnt_d = '0;
         auth_cnt_d  = '0;
         hold_cnt_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (go) begin
                  if (both_full) begin
                     state_d = StReq;
                     // A write racing an accepted go is dropped.
                     if (wr_valid) err_set = 1'b1;
                  end else begin
                     err_set = 1'b1;
                  end
               end
               if (wr_valid && !(go && both_full)) begin
                  if (!wr_sel) begin
                     if (trans_full) begin
                        err_set = 1'b1;
                     end else begin
                        for (int unsigned k = 0; k < NumWords; k++) begin
                           if (trans_cnt_q == CntW'(k)) trans_buf_d[k*WORD_W +: WORD_W] = wr_data;
                        end
                        trans_cnt_d = trans_cnt_q + 1'b1;
                     end
                  end else begin
                     if (auth_full) begin
                        err_set = 1'b1;
                     end else begin
                        for (int unsigned k = 0; k < NumWords; k++) begin
                           if (auth_cnt_q == CntW'(k)) auth_buf_d[k*WORD_W +: WORD_W] = wr_data;
                        end
                        auth_cnt_d = auth_cnt_q + 1'b1;
                     end
                  end
               end
            end
            StReq: begin
               state_d    = StAuth;
               hold_cnt_d = '0;
               if (wr_valid || go) err_set = 1'b1;
            end
            StAuth: begin
               if (hold_cnt_q == HoldLast) begin
                  state_d = StClear;
               end else begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
               if (wr_valid || go) err_set = 1'b1;
            end
            StClear: begin
               state_d     = StIdle;
               trans_buf_d = '0;
               auth_buf_d  = '0;
               trans_cnt_d = '0;
               auth_cnt_d  = '0;
               hold_cnt_d  = '0;
               if (wr_valid || go) err_set = 1'b1;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      // Set-dominant sticky error.
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State and data registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         trans_buf_q <= '0;
         auth_buf_q  <= '0;
         trans_cnt_q <= '0;
         auth_cnt_q  <= '0;
         hold_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         trans_buf_q <= trans_buf_d;
         auth_buf_q  <= auth_buf_d;
         trans_cnt_q <= trans_cnt_d;
         auth_cnt_q  <= auth_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_mcse_lc_request_loader.sv
// Directed bench for mcse_lc_request_loader: fill, request timing, error
// handling, abort and asynchronous reset behaviour.
module tb_mcse_lc_request_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_valid;
   logic         wr_sel;
   logic [31:0]  wr_data;
   logic         go;
   logic         abort;
   logic         err_clr;
   logic [255:0] lc_transition_id;
   logic         lc_transition_request;
   logic [255:0] lc_authentication_id;
   logic         lc_authentication_valid;
   logic         busy;
   logic         trans_full;
   logic         auth_full;
   logic         err;

   int checks = 0;
   int passed = 0;

   mcse_lc_request_loader #(
      .ID_WIDTH  (256),
      .WORD_W    (32),
      .AUTH_HOLD (16)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .wr_valid                (wr_valid),
      .wr_sel                  (wr_sel),
      .wr_data                 (wr_data),
      .go                      (go),
      .abort                   (abort),
      .err_clr                 (err_clr),
      .lc_transition_id        (lc_transition_id),
      .lc_transition_request   (lc_transition_request),
      .lc_authentication_id    (lc_authentication_id),
      .lc_authentication_valid (lc_authentication_valid),
      .busy                    (busy),
      .trans_full              (trans_full),
      .auth_full               (auth_full),
      .err                     (err)
   );

   always #5 clk = ~clk;

   // Expected 256-bit ID when words base, base+1, ... are written in order.
   function automatic logic [255:0] make_id(input logic [31:0] base);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(i);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic sel, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_sel   = sel;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      checks++;
      if ({busy, lc_transition_request, lc_authentication_valid, trans_full, auth_full, err} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {busy, lc_transition_request,
                  lc_authentication_valid, trans_full, auth_full, err});
      else passed++;
      checks++;
      if ({lc_transition_id, lc_authentication_id} !== 512'b0)
         $display("FAIL reset_ids: got %h/%h want 0", lc_transition_id, lc_authentication_id);
      else passed++;
      rst = 1'b1;
      step();
      checks++;
      if ({busy, err, trans_full, auth_full} !== 4'b0)
         $display("FAIL post_reset_flags: got %b want 0000", {busy, err, trans_full, auth_full});
      else passed++;
   endtask

   task automatic test_full_request();
      int req_cnt, valid_cnt, busy_cnt, first_valid;
      logic stable;
      for (int i = 0; i < 7; i++) wr_word(1'b0, 32'h1000_0000 + 32'(i));
      checks++;
      if (trans_full !== 1'b0) $display("FAIL trans_full_at_7: got %b want 0", trans_full);
      else passed++;
      wr_word(1'b0, 32'h1000_0007);
      checks++;
      if (trans_full !== 1'b1) $display("FAIL trans_full_at_8: got %b want 1", trans_full);
      else passed++;
      for (int i = 0; i < 8; i++) wr_word(1'b1, 32'hA000_0000 + 32'(i));
      checks++;
      if (auth_full !== 1'b1) $display("FAIL auth_full_at_8: got %b want 1", auth_full);
      else passed++;

      pulse_go();
      checks++;
      if ({busy, lc_transition_request, lc_authentication_valid} !== 3'b110)
         $display("FAIL req_cycle_flags: got %b want 110",
                  {busy, lc_transition_request, lc_authentication_valid});
      else passed++;
      checks++;
      if (lc_transition_id !== make_id(32'h1000_0000))
         $display("FAIL trans_id: got %h want %h", lc_transition_id, make_id(32'h1000_0000));
      else passed++;
      checks++;
      if (lc_authentication_id !== make_id(32'hA000_0000))
         $display("FAIL auth_id: got %h want %h", lc_authentication_id, make_id(32'hA000_0000));
      else passed++;
      checks++;
      if ({lc_transition_id[255:224], lc_transition_id[31:0]} !== {32'h1000_0007, 32'h1000_0000})
         $display("FAIL trans_id_ends: got %h %h want 10000007 10000000",
                  lc_transition_id[255:224], lc_transition_id[31:0]);
      else passed++;

      req_cnt     = 1;
      valid_cnt   = 0;
      busy_cnt    = 1;
      first_valid = -1;
      stable      = 1'b1;
      for (int c = 0; c < 40 && busy; c++) begin
         step();
         if (busy) busy_cnt++;
         if (lc_transition_request) req_cnt++;
         if (lc_authentication_valid) begin
            if (first_valid < 0) first_valid = c;
            valid_cnt++;
            if (lc_transition_id !== make_id(32'h1000_0000) ||
                lc_authentication_id !== make_id(32'hA000_0000)) stable = 1'b0;
         end
      end
      checks++;
      if (req_cnt != 1) $display("FAIL req_pulse_len: got %0d want 1", req_cnt);
      else passed++;
      checks++;
      if (valid_cnt != 16) $display("FAIL valid_len: got %0d want 16", valid_cnt);
      else passed++;
      checks++;
      if (first_valid != 0) $display("FAIL valid_start: got %0d want 0", first_valid);
      else passed++;
      checks++;
      if (busy_cnt != 18) $display("FAIL busy_span: got %0d want 18", busy_cnt);
      else passed++;
      checks++;
      if (stable !== 1'b1) $display("FAIL ids_stable: got %b want 1", stable);
      else passed++;
      checks++;
      if ({lc_transition_id, lc_authentication_id} !== 512'b0)
         $display("FAIL ids_after: got %h/%h want 0", lc_transition_id, lc_authentication_id);
      else passed++;
      checks++;
      if ({busy, trans_full, auth_full, err, lc_authentication_valid} !== 5'b0)
         $display("FAIL flags_after: got %b want 00000",
                  {busy, trans_full, auth_full, err, lc_authentication_valid});
      else passed++;
   endtask

   task automatic test_go_not_full();
      for (int i = 0; i < 8; i++) wr_word(1'b0, 32'h2000_0000 + 32'(i));
      for (int i = 0; i < 7; i++) wr_word(1'b1, 32'hB000_0000 + 32'(i));
      checks++;
      if ({trans_full, auth_full} !== 2'b10)
         $display("FAIL partial_full: got %b want 10", {trans_full, auth_full});
      else passed++;
      pulse_go();
      checks++;
      if ({busy, lc_transition_request, err} !== 3'b001)
         $display("FAIL go_not_full: got %b want 001", {busy, lc_transition_request, err});
      else passed++;
      wr_word(1'b0, 32'h2000_0008);
      checks++;
      if ({err, trans_full, busy} !== 3'b110)
         $display("FAIL overflow_write: got %b want 110", {err, trans_full, busy});
      else passed++;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) $display("FAIL err_clr: got %b want 0", err);
      else passed++;
      wr_word(1'b1, 32'hB000_0007);
      checks++;
      if ({auth_full, err} !== 2'b10)
         $display("FAIL buffers_retained: got %b want 10", {auth_full, err});
      else passed++;
   endtask

   task automatic test_write_in_auth();
      int valid_cnt;
      pulse_go();
      checks++;
      if (lc_transition_request !== 1'b1)
         $display("FAIL auth_test_req: got %b want 1", lc_transition_request);
      else passed++;
      valid_cnt = 0;
      for (int c = 0; c < 40 && busy; c++) begin
         if (c == 2) begin
            wr_valid = 1'b1;
            wr_sel   = 1'b0;
            wr_data  = 32'hDEAD_BEEF;
         end
         step();
         wr_valid = 1'b0;
         if (lc_authentication_valid) valid_cnt++;
         if (c == 2) begin
            checks++;
            if (err !== 1'b1) $display("FAIL write_in_auth_err: got %b want 1", err);
            else passed++;
            checks++;
            if (lc_transition_id !== make_id(32'h2000_0000))
               $display("FAIL write_in_auth_id: got %h want %h", lc_transition_id,
                        make_id(32'h2000_0000));
            else passed++;
         end
      end
      checks++;
      if (valid_cnt != 16) $display("FAIL write_in_auth_len: got %0d want 16", valid_cnt);
      else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL write_in_auth_done: got %b want 0", busy);
      else passed++;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) $display("FAIL err_clr_after_auth: got %b want 0", err);
      else passed++;
   endtask

   task automatic test_abort();
      for (int i = 0; i < 8; i++) wr_word(1'b0, 32'h3000_0000 + 32'(i));
      for (int i = 0; i < 8; i++) wr_word(1'b1, 32'hC000_0000 + 32'(i));
      pulse_go();
      repeat (5) step();
      checks++;
      if (lc_authentication_valid !== 1'b1)
         $display("FAIL abort_pre_valid: got %b want 1", lc_authentication_valid);
      else passed++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({busy, lc_transition_request, lc_authentication_valid, trans_full, auth_full, err} !== 6'b0)
         $display("FAIL abort_flags: got %b want 000000", {busy, lc_transition_request,
                  lc_authentication_valid, trans_full, auth_full, err});
      else passed++;
      checks++;
      if ({lc_transition_id, lc_authentication_id} !== 512'b0)
         $display("FAIL abort_ids: got %h/%h want 0", lc_transition_id, lc_authentication_id);
      else passed++;
      step();
      checks++;
      if ({busy, lc_authentication_valid} !== 2'b00)
         $display("FAIL abort_stays_idle: got %b want 00", {busy, lc_authentication_valid});
      else passed++;
      // Abort racing an overflow write and a go must not flag an error.
      for (int i = 0; i < 8; i++) wr_word(1'b0, 32'h3100_0000 + 32'(i));
      abort    = 1'b1;
      wr_valid = 1'b1;
      wr_sel   = 1'b0;
      go       = 1'b1;
      step();
      abort    = 1'b0;
      wr_valid = 1'b0;
      go       = 1'b0;
      checks++;
      if ({err, trans_full, busy} !== 3'b000)
         $display("FAIL abort_discard: got %b want 000", {err, trans_full, busy});
      else passed++;
   endtask

   task automatic test_err_clr_overflow();
      for (int i = 0; i < 8; i++) wr_word(1'b0, 32'h4000_0000 + 32'(i));
      wr_valid = 1'b1;
      wr_sel   = 1'b0;
      wr_data  = 32'h4000_0008;
      err_clr  = 1'b1;
      step();
      wr_valid = 1'b0;
      err_clr  = 1'b0;
      checks++;
      if (err !== 1'b1) $display("FAIL err_set_dominant: got %b want 1", err);
      else passed++;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) $display("FAIL err_clr_alone: got %b want 0", err);
      else passed++;
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      logic seen;
      for (int i = 0; i < 8; i++) wr_word(1'b0, 32'h5000_0000 + 32'(i));
      for (int i = 0; i < 8; i++) wr_word(1'b1, 32'hD000_0000 + 32'(i));
      pulse_go();
      checks++;
      if (lc_transition_request !== 1'b1)
         $display("FAIL rst_test_req: got %b want 1", lc_transition_request);
      else passed++;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({lc_transition_request, busy, lc_authentication_valid} !== 3'b000)
         $display("FAIL async_rst_flags: got %b want 000",
                  {lc_transition_request, busy, lc_authentication_valid});
      else passed++;
      checks++;
      if ({lc_transition_id, lc_authentication_id} !== 512'b0)
         $display("FAIL async_rst_ids: got %h/%h want 0", lc_transition_id, lc_authentication_id);
      else passed++;
      #2 rst = 1'b1;
      step();
      checks++;
      if ({busy, trans_full, auth_full, err} !== 4'b0)
         $display("FAIL rst_release: got %b want 0000", {busy, trans_full, auth_full, err});
      else passed++;
      seen = 1'b0;
      repeat (3) begin
         step();
         if (lc_authentication_valid || lc_transition_request) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL no_partial_resume: got %b want 0", seen);
      else passed++;
      pulse_go();
      checks++;
      if ({busy, err} !== 2'b01)
         $display("FAIL go_after_rst_empty: got %b want 01", {busy, err});
      else passed++;
   endtask

   initial begin
      rst      = 1'b0;
      wr_valid = 1'b0;
      wr_sel   = 1'b0;
      wr_data  = '0;
      go       = 1'b0;
      abort    = 1'b0;
      err_clr  = 1'b0;
      test_reset();
      test_full_request();
      test_go_not_full();
      test_write_in_auth();
      test_abort();
      test_err_clr_overflow();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/mcse_lc_request_loader.md
# mcse_lc_request_loader

Upstream feeder for the MCSE control unit's lifecycle-protection inputs. It assembles a 256-bit lifecycle transition ID and a 256-bit authentication ID from 32-bit word writes issued by the host/GPIO path, then on command presents them with a one-cycle `lc_transition_request` pulse followed by a timed `lc_authentication_valid` window. Afterwards it zeroizes all buffered identifiers. Outside the request window it never exposes identifier bits.

## Interface

Parameters:
- `ID_WIDTH`, 256, width of each identifier; must be a multiple of `WORD_W`.
- `WORD_W`, 32, width of host write word.
- `AUTH_HOLD`, 16, cycles `lc_authentication_valid` stays high; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host word write strobe.
- `wr_sel`  in  1  target buffer: 0 = transition ID, 1 = authentication ID.
- `wr_data`  in  `WORD_W`  write word.
- `go`  in  1  commit request.
- `abort`  in  1  synchronous cancel and zeroize.
- `err_clr`  in  1  clears sticky error.
- `lc_transition_id`  out  `ID_WIDTH`  to control unit.
- `lc_transition_request`  out  1  one-cycle request pulse.
- `lc_authentication_id`  out  `ID_WIDTH`  to control unit.
- `lc_authentication_valid`  out  1  authentication window.
- `busy`  out  1  state ≠ IDLE.
- `trans_full`  out  1  transition buffer holds `ID_WIDTH/WORD_W` words.
- `auth_full`  out  1  authentication buffer full.
- `err`  out  1  sticky protocol error.

## Operation

- Two buffers, each `NW = ID_WIDTH/WORD_W` words, with independent word counters (0..NW).
- Word k lands in bits `[k*WORD_W +: WORD_W]`, so the first write is the LSW.
- FSM states: IDLE, REQ, AUTH, CLEAR. Reset state is IDLE.
- IDLE:
  - `wr_valid` with count < NW: store the word and increment the selected counter.
  - `wr_valid` with count == NW: word dropped, `err` set.
  - `go` with both full: go to REQ. A `wr_valid` in the same cycle is dropped and sets `err`.
  - `go` with either buffer not full: `err` set, stay in IDLE, buffers retained.
- REQ: one cycle with `lc_transition_request`=1, then AUTH; the AUTH counter loads 0.
- AUTH: `lc_authentication_valid`=1; counter increments each cycle; leave for CLEAR when counter == `AUTH_HOLD-1`.
- CLEAR: one cycle; both buffers and counters zeroed; then IDLE.
- `wr_valid` or `go` in REQ, AUTH, or CLEAR: ignored, `err` set.
- `abort` (any state, highest priority):
  - Next cycle: state IDLE, buffers and counters zeroed, all lc outputs 0.
  - Writes or `go` in the same cycle are discarded without setting `err`.
- `err`: set-dominant. When a set condition and `err_clr` occur in the same cycle, `err` stays 1.
- Identifier outputs:
  - Driven from the buffers only in REQ and AUTH; forced to all-zero otherwise.
  - Stable throughout REQ→AUTH.
- `trans_full`/`auth_full` are decoded from the counters; `busy` is decoded from state.

## Timing

- Reset (asynchronous assert, synchronous deassert handled upstream): all outputs 0, buffers 0, counters 0, state IDLE, `err` 0.
- `go` accepted at edge E:
  - REQ during cycle E+1, so `lc_transition_request` is high for exactly one cycle.
  - `lc_authentication_valid` high for cycles E+2 .. E+1+`AUTH_HOLD`.
  - CLEAR at cycle E+2+`AUTH_HOLD`.
  - `busy` low and IDLE at E+3+`AUTH_HOLD`.
- Total busy span: `AUTH_HOLD`+2 cycles.
- Write accepted at edge E: `*_full` reflects the new count in cycle E+1.
- Reset asserted mid-request: outputs drop to 0 immediately (asynchronous); no partial pulse is extended.
- `abort` during AUTH at edge E: `lc_authentication_valid` is 0 in cycle E+1.
- No combinational path from any input to any output.

## Test plan

- Reset, 8 transition writes 0x1000_0000..0x1000_0007, 8 auth writes 0xA000_0000..7, `go`:
  - `lc_transition_id` reads 0x10000007_…_10000000 in REQ.
  - Request pulse is 1 cycle; valid is high exactly 16 cycles.
  - Then all outputs 0, `trans_full`=`auth_full`=0.
- `go` with 7 auth words loaded → `err`=1, no request; a 9th transition write → `err` stays 1; `err_clr` → `err`=0.
- `wr_valid` in AUTH → `err`=1; buffer contents unchanged on the outputs; cycle count unchanged.
- `abort` in 5th AUTH cycle → next cycle valid=0, ids=0, `busy`=0, `err`=0.
- `err_clr` coincident with an overflow write → `err` remains 1.
- `rst` low asynchronously mid-REQ → `lc_transition_request` falls without waiting for a clock edge; after release, buffers read empty.
